// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the image-filter pipeline.
// It selects the writeback datum, which is the memory word, the memory byte
// or the ALU result. It drives registered scalar (C) and vector (V)
// register-file write ports.
// Optional feature macro WB_PACK_EN builds the byte-packing sequencer. That
// sequencer assembles four filtered pixel bytes into one vector word.
// Handshake: there is no ready path. An instruction is accepted when WE=1 and
// PROHIB_WB=0. Each accepted write produces a one-cycle strobe on the next
// edge. Address and data hold their values while the strobe is low.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic        SEL_DAT,
  input  logic        SEL_C,
  input  logic        WE_C,
  input  logic        WE_V,
  input  logic        SEL_STO,
  input  logic        PROHIB_WB,
  input  logic [31:0] Do,
  input  logic [7:0]  Dob,
  input  logic [31:0] ALU_Result,
  input  logic [3:0]  Rg,
  output logic        rf_c_we,
  output logic [3:0]  rf_c_addr,
  output logic [31:0] rf_c_data,
  output logic        rf_v_we,
  output logic [3:0]  rf_v_addr,
  output logic [31:0] rf_v_data,
  output logic        pack_busy,
  output logic [1:0]  pack_lane
);

  logic        valid;
  logic [31:0] sel_w;

  // Next-cycle vector port values, produced by the pack logic or the direct path
  logic        v_we_d;
  logic [3:0]  v_addr_d;
  logic [31:0] v_data_d;

  assign valid = WE & ~PROHIB_WB;

  // Writeback datum mux: memory byte is zero-extended
  always_comb begin
    sel_w = ALU_Result;
    if (SEL_DAT) begin
      sel_w = SEL_C ? {24'b0, Dob} : Do;
    end
  end

  // Scalar write port register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_c_we   <= 1'b0;
      rf_c_addr <= 4'd0;
      rf_c_data <= 32'd0;
    end else begin
      rf_c_we <= valid & WE_C;
      if (valid && WE_C) begin
        rf_c_addr <= Rg;
        rf_c_data <= sel_w;
      end
    end
  end

`ifdef WB_PACK_EN
  typedef enum logic {IDLE = 1'b0, PACK = 1'b1} pack_state_t;

  // pack_state is the observable FSM state; pack_busy mirrors it
  pack_state_t pack_state, state_d;
  logic [31:0] pack_buf, buf_d;
  logic [3:0]  paddr, paddr_d;
  logic [1:0]  lane, lane_d;
  logic [7:0]  sel_b;
  logic [31:0] merged;

  assign sel_b  = sel_w[7:0];
  assign merged = pack_buf | ({24'b0, sel_b} << {lane, 3'b000});

  // Pack FSM next state and vector port selection
  always_comb begin
    state_d  = pack_state;
    buf_d    = pack_buf;
    paddr_d  = paddr;
    lane_d   = lane;
    v_we_d   = 1'b0;
    v_addr_d = rf_v_addr;
    v_data_d = rf_v_data;
    if (valid && WE_V && !SEL_STO) begin
      // A direct write wins the port and drops any partial pack
      v_we_d   = 1'b1;
      v_addr_d = Rg;
      v_data_d = sel_w;
      state_d  = IDLE;
      buf_d    = 32'd0;
      lane_d   = 2'd0;
    end else if (valid && WE_V && SEL_STO) begin
      case (pack_state)
        IDLE: begin
          buf_d   = {24'b0, sel_b};
          paddr_d = Rg;
          lane_d  = 2'd1;
          state_d = PACK;
        end
        PACK: begin
          if (Rg == paddr) begin
            if (lane == 2'd3) begin
              v_we_d   = 1'b1;
              v_addr_d = paddr;
              v_data_d = merged;
              buf_d    = 32'd0;
              lane_d   = 2'd0;
              state_d  = IDLE;
            end else begin
              buf_d  = merged;
              lane_d = lane + 2'd1;
            end
          end else begin
            // Destination changed: flush the partial word and start a new one
            v_we_d   = 1'b1;
            v_addr_d = paddr;
            v_data_d = pack_buf;
            buf_d    = {24'b0, sel_b};
            paddr_d  = Rg;
            lane_d   = 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pack FSM state and buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pack_state <= IDLE;
      pack_buf   <= 32'd0;
      paddr      <= 4'd0;
      lane       <= 2'd0;
    end else begin
      pack_state <= state_d;
      pack_buf   <= buf_d;
      paddr      <= paddr_d;
      lane       <= lane_d;
    end
  end

  assign pack_busy = (pack_state == PACK);
  assign pack_lane = lane;
`else
  logic unused_sel_sto;
  assign unused_sel_sto = SEL_STO;

  // Without the packer every accepted WE_V is a direct word write
  always_comb begin
    v_we_d   = valid & WE_V;
    v_addr_d = rf_v_addr;
    v_data_d = rf_v_data;
    if (valid && WE_V) begin
      v_addr_d = Rg;
      v_data_d = sel_w;
    end
  end

  assign pack_busy = 1'b0;
  assign pack_lane = 2'd0;
`endif

  // Vector write port register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_v_we   <= 1'b0;
      rf_v_addr <= 4'd0;
      rf_v_data <= 32'd0;
    end else begin
      rf_v_we   <= v_we_d;
      rf_v_addr <= v_addr_d;
      rf_v_data <= v_data_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven bench for wb_stage with an expected-value queue.
// The pack rows are built only when WB_PACK_EN is defined. Without it, the
// direct-write fallback rows are built instead.
module tb_wb_stage;

  localparam int W = 77;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        WE, SEL_DAT, SEL_C, WE_C, WE_V, SEL_STO, PROHIB_WB;
  logic [31:0] Do, ALU_Result;
  logic [7:0]  Dob;
  logic [3:0]  Rg;
  logic        rf_c_we, rf_v_we, pack_busy;
  logic [3:0]  rf_c_addr, rf_v_addr;
  logic [31:0] rf_c_data, rf_v_data;
  logic [1:0]  pack_lane;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .WE(WE), .SEL_DAT(SEL_DAT), .SEL_C(SEL_C),
    .WE_C(WE_C), .WE_V(WE_V), .SEL_STO(SEL_STO), .PROHIB_WB(PROHIB_WB),
    .Do(Do), .Dob(Dob), .ALU_Result(ALU_Result), .Rg(Rg),
    .rf_c_we(rf_c_we), .rf_c_addr(rf_c_addr), .rf_c_data(rf_c_data),
    .rf_v_we(rf_v_we), .rf_v_addr(rf_v_addr), .rf_v_data(rf_v_data),
    .pack_busy(pack_busy), .pack_lane(pack_lane)
  );

  typedef struct {
    logic        rst_n, we, prohib, sel_dat, sel_c, we_c, we_v, sel_sto;
    logic [31:0] d_word;
    logic [7:0]  d_byte;
    logic [31:0] alu;
    logic [3:0]  rg;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Expected output packing: {c_we, c_addr, c_data, v_we, v_addr, v_data, busy, lane}
  function automatic logic [W-1:0] ex(input logic cw, input logic [3:0] ca,
                                      input logic [31:0] cd, input logic vw,
                                      input logic [3:0] va, input logic [31:0] vd,
                                      input logic busy, input logic [1:0] ln);
    return {cw, ca, cd, vw, va, vd, busy, ln};
  endfunction

  function automatic vec_t mk(input logic r, input logic we, input logic pr,
                              input logic sd, input logic sc, input logic wc,
                              input logic wv, input logic ss, input logic [31:0] dw,
                              input logic [7:0] db, input logic [31:0] alu,
                              input logic [3:0] rg, input logic [W-1:0] e);
    vec_t v;
    v.rst_n = r; v.we = we; v.prohib = pr; v.sel_dat = sd; v.sel_c = sc;
    v.we_c = wc; v.we_v = wv; v.sel_sto = ss; v.d_word = dw; v.d_byte = db;
    v.alu = alu; v.rg = rg; v.exp = e;
    return v;
  endfunction

  // Scoreboard compare of one output group
  task automatic check(input string name, input int idx,
                       input logic [W-1:0] got, input logic [W-1:0] want,
                       input logic [W-1:0] mask);
    n_cmp++;
    if ((got & mask) !== (want & mask)) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, got & mask, want & mask);
    end
  endtask

  // Driver: apply one row at the falling edge, queue its expectation, sample after the rising edge
  task automatic step(input vec_t v, input int idx);
    logic [W-1:0] got;
    logic [W-1:0] want;
    @(negedge clk);
    rst_n = v.rst_n; WE = v.we; PROHIB_WB = v.prohib; SEL_DAT = v.sel_dat;
    SEL_C = v.sel_c; WE_C = v.we_c; WE_V = v.we_v; SEL_STO = v.sel_sto;
    Do = v.d_word; Dob = v.d_byte; ALU_Result = v.alu; Rg = v.rg;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    got = {rf_c_we, rf_c_addr, rf_c_data, rf_v_we, rf_v_addr, rf_v_data, pack_busy, pack_lane};
    want = exp_q.pop_front();
    check("c_port", idx, got, want, {{37{1'b1}}, 40'd0});
    check("v_port", idx, got, want, {37'd0, {37{1'b1}}, 3'd0});
    check("pack",   idx, got, want, {74'd0, 3'b111});
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; WE = 1'b0; PROHIB_WB = 1'b0; SEL_DAT = 1'b0; SEL_C = 1'b0;
    WE_C = 1'b0; WE_V = 1'b0; SEL_STO = 1'b0; Do = '0; Dob = '0;
    ALU_Result = '0; Rg = '0;

    //               rst we pr sd sc wc wv ss  Do            Dob    ALU           Rg
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        8'h0,  32'h0,        4'd0,
                     ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 32'hFFFF0000, 8'h3C, 32'h12345678, 4'd3,
                     ex(1, 3, 32'h12345678, 0, 0, 32'h0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 32'hFFFFFFFF, 8'hA5, 32'h0,        4'd7,
                     ex(1, 7, 32'hA5, 1, 7, 32'hA5, 0, 0)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 32'h0,        8'h0,  32'h99999999, 4'd9,
                     ex(0, 7, 32'hA5, 0, 7, 32'hA5, 0, 0)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 32'h0,        8'h0,  32'h88888888, 4'd8,
                     ex(0, 7, 32'hA5, 0, 7, 32'hA5, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 32'hCAFEF00D, 8'hEE, 32'h1,        4'd15,
                     ex(0, 7, 32'hA5, 1, 15, 32'hCAFEF00D, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 32'h5,        8'h6,  32'h0,        4'd0,
                     ex(1, 0, 32'h0, 0, 15, 32'hCAFEF00D, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 32'h7,        8'h8,  32'h9,        4'd1,
                     ex(0, 0, 32'h0, 0, 15, 32'hCAFEF00D, 0, 0)));
`ifdef WB_PACK_EN
    // Four bytes to Rg=2 with a stall in the middle; the byte comes from ALU_Result[7:0]
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'hABCDEF11, 4'd2,
                     ex(0, 0, 32'h0, 0, 15, 32'hCAFEF00D, 1, 1)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'hFFFFFFFF, 8'h22, 32'h0, 4'd2,
                     ex(0, 0, 32'h0, 0, 15, 32'hCAFEF00D, 1, 2)));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 1, 1, 32'h0, 8'h99, 32'h0, 4'd2,
                     ex(0, 0, 32'h0, 0, 15, 32'hCAFEF00D, 1, 2)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'h33, 32'h0, 4'd2,
                     ex(0, 0, 32'h0, 0, 15, 32'hCAFEF00D, 1, 3)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'h44, 32'h0, 4'd2,
                     ex(0, 0, 32'h0, 1, 2, 32'h44332211, 0, 0)));
    // Flush on a destination change
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'hAA, 32'h0, 4'd1,
                     ex(0, 0, 32'h0, 0, 2, 32'h44332211, 1, 1)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'hBB, 32'h0, 4'd1,
                     ex(0, 0, 32'h0, 0, 2, 32'h44332211, 1, 2)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'hCC, 32'h0, 4'd5,
                     ex(0, 0, 32'h0, 1, 1, 32'h0000BBAA, 1, 1)));
    // A squashed pack byte changes nothing
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 1, 1, 32'h0, 8'hDD, 32'h0, 4'd5,
                     ex(0, 0, 32'h0, 0, 1, 32'h0000BBAA, 1, 1)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'hEE, 32'h0, 4'd5,
                     ex(0, 0, 32'h0, 0, 1, 32'h0000BBAA, 1, 2)));
    // A direct write drops the partial pack
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 8'h0, 32'hDEADBEEF, 4'd4,
                     ex(0, 0, 32'h0, 1, 4, 32'hDEADBEEF, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'h00000055, 4'd4,
                     ex(0, 0, 32'h0, 0, 4, 32'hDEADBEEF, 1, 1)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 8'h0, 32'hDEADBEEF, 4'd4,
                     ex(0, 0, 32'h0, 1, 4, 32'hDEADBEEF, 0, 0)));
    // Scalar and pack in the same cycle, then reset mid-pack
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 32'h0, 8'h0, 32'h12340066, 4'd8,
                     ex(1, 8, 32'h12340066, 0, 4, 32'hDEADBEEF, 1, 1)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'h00000077, 4'd8,
                     ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'h0, 32'h0, 4'd0,
                     ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'h00000001, 4'd8,
                     ex(0, 0, 32'h0, 0, 0, 32'h0, 1, 1)));
`else
    // SEL_STO is ignored: every accepted WE_V writes the full word directly
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'h01020304, 4'd2,
                     ex(0, 0, 32'h0, 1, 2, 32'h01020304, 0, 0)));
    tbl.push_back(mk(1, 1, 0, 1, 1, 0, 1, 1, 32'h0, 8'h77, 32'h0, 4'd6,
                     ex(0, 0, 32'h0, 1, 6, 32'h00000077, 0, 0)));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 1, 32'h0, 8'h0, 32'h0BADF00D, 4'd9,
                     ex(0, 0, 32'h0, 0, 6, 32'h00000077, 0, 0)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, 32'h0, 8'h0, 32'h0BADF00D, 4'd9,
                     ex(0, 0, 32'h0, 0, 0, 32'h0, 0, 0)));
`endif

    // Random stall rows: WE=0 never writes and holds the current outputs
    for (int i = 0; i < 4; i++) begin
      vec_t r;
      logic [W-1:0] held;
      held = tbl[tbl.size()-1].exp;
      held[W-1] = 1'b0;
      held[39]  = 1'b0;
      r = mk(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1, 1, 1'($urandom_range(0, 1)),
             $urandom, 8'($urandom_range(0, 255)), $urandom,
             4'($urandom_range(0, 15)), held);
      tbl.push_back(r);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
    end

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
